// File: rtl/cdu_read_counter.sv
// Read counter for one CDU channel: steps a 16-bit angle toward null from the
// ternary error triggers, drives the fine ladder, and queues rate-limited pulses.
module cdu_read_counter #(
    parameter int unsigned SLOW_DIV = 64,
    parameter int unsigned FAST_DIV = 4,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned OUT_GAP  = 8,
    parameter int unsigned PEND_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        _TLF1H,
    input  logic        _TLF2H,
    input  logic        _ERRNEG,
    input  logic        _ZERO,
    output logic [15:0] angle,
    output logic        _D15,
    output logic        _D16,
    output logic        _D17,
    output logic        _D18,
    output logic        _D19,
    output logic        _D20,
    output logic        _D21,
    output logic        _CDUP,
    output logic        _CDUM,
    output logic        ovf
);

    localparam int unsigned TW = $clog2(SLOW_DIV + 1);
    localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned GW = $clog2(OUT_GAP);
    localparam logic signed [PEND_W-1:0] P_MAX = PEND_W'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [PEND_W-1:0] P_MIN = PEND_W'(1 << (PEND_W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE
    } state_t;

    state_t                    state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d, thr_m1;
    logic [SW-1:0]             settle_q, settle_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic signed [PEND_W-1:0]  pend_q, pend_d;
    logic                      trig, step, drain, sat;

    assign trig   = _TLF1H | _TLF2H;
    assign thr_m1 = _TLF2H ? TW'(FAST_DIV - 1) : TW'(SLOW_DIV - 1);

    // IDLE behaves as RUN with a zero timer, so a trigger can step on its first clock
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        step     = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (!trig) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q >= thr_m1) begin
                    step    = 1'b1;
                    timer_d = '0;
                    if (SETTLE == 0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = SW'(SETTLE);
                    end
                end else begin
                    state_d = S_RUN;
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_q <= SW'(1)) begin
                    settle_d = '0;
                    state_d  = trig ? S_RUN : S_IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturation is judged on the pre-drain count; the drain still applies
    always_comb begin
        drain  = (gap_q == '0) && (pend_q != '0);
        sat    = step && (_ERRNEG ? (pend_q == P_MIN) : (pend_q == P_MAX));
        pend_d = pend_q;
        if (drain) begin
            pend_d = pend_q[PEND_W-1] ? pend_q + PEND_W'(1) : pend_q - PEND_W'(1);
        end
        if (step && !sat) begin
            pend_d = _ERRNEG ? pend_d - PEND_W'(1) : pend_d + PEND_W'(1);
        end
        if (drain) begin
            gap_d = GW'(OUT_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else begin
            gap_d = gap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !_ZERO) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            settle_q <= '0;
            gap_q    <= '0;
            pend_q   <= '0;
            angle    <= '0;
            ovf      <= 1'b0;
            _CDUP    <= 1'b1;
            _CDUM    <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            if (step) begin
                angle <= _ERRNEG ? angle - 16'd1 : angle + 16'd1;
            end
            ovf   <= ovf | sat;
            _CDUP <= !(drain && !pend_q[PEND_W-1]);
            _CDUM <= !(drain && pend_q[PEND_W-1]);
        end
    end

    assign _D15 = ~angle[6];
    assign _D16 = ~angle[5];
    assign _D17 = ~angle[4];
    assign _D18 = ~angle[3];
    assign _D19 = ~angle[2];
    assign _D20 = ~angle[1];
    assign _D21 = ~angle[0];

endmodule

// File: doc/cdu_read_counter.md
# cdu_read_counter

Read counter for one CDU channel. It consumes the ternary error triggers (`_TLF1H` fine, `_TLF2H` high) from the main summing amplifier and quadrant selector, and steps a 16-bit angle register toward null. The low seven angle bits drive that stage's fine ladder switches `_D15`..`_D21`, which closes the servo loop. Every step is also queued and emitted as a rate-limited, active-low increment/decrement pulse toward the computer interface.

## Interface
- `SLOW_DIV`, 64: clocks per step while only the fine trigger is asserted (≥2).
- `FAST_DIV`, 4: clocks per step while the high trigger is asserted (≥1, < `SLOW_DIV`).
- `SETTLE`, 2: clocks after each step during which the triggers are ignored (ladder settling, ≥0).
- `OUT_GAP`, 8: minimum clocks from one output pulse to the next (≥2).
- `PEND_W`, 6: width of the signed pending-pulse counter.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `_TLF1H` in 1: high = |error| above the fine threshold.
- `_TLF2H` in 1: high = |error| above the high threshold.
- `_ERRNEG` in 1: high = error negative (count down); low = count up.
- `_ZERO` in 1: active-low synchronous clear of the counter state.
- `angle` out 16: read counter, LSB = 360°/65536, wraps modulo 2^16.
- `_D15`..`_D21` out 1 each: fine ladder drives, active low; `_D15` = ~`angle[6]` … `_D21` = ~`angle[0]`.
- `_CDUP` out 1: one-clock low pulse per queued up-count.
- `_CDUM` out 1: one-clock low pulse per queued down-count.
- `ovf` out 1: sticky flag, set when the pending counter saturates.

## Operation
- The trigger sampler has three states.
  - IDLE: the rate timer is 0 and no trigger is active.
  - RUN: a trigger is active and the timer is counting.
  - SETTLE: the settle counter is counting down and triggers are ignored.
- IDLE→RUN when `_TLF1H` or `_TLF2H` is high. `_TLF2H` high with `_TLF1H` low is treated as active at high rate.
- In RUN, the threshold is `FAST_DIV` if `_TLF2H` is high, else `SLOW_DIV`. The threshold is re-evaluated every clock.
- Step condition in RUN: trigger active and timer ≥ threshold−1. On a step:
  - `angle` ±1, where `_ERRNEG` is sampled the same clock.
  - The timer clears.
  - The state goes to SETTLE, or stays in RUN if `SETTLE` = 0.
- RUN→IDLE, with the timer cleared, when both triggers are low.
- SETTLE lasts exactly `SETTLE` clocks, then → RUN if a trigger is high, else → IDLE.
- Wrap: 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF. Each wrap queues a pulse like any other step.
- Pending counter `pend` (signed, `PEND_W` bits): +1 per up-step, −1 per down-step.
- Drain: when the gap timer is idle and `pend` ≠ 0, assert `_CDUP` (`pend`>0) or `_CDUM` (`pend`<0) low for one clock and move `pend` one toward 0.
- A step and a drain in the same clock apply both; the net change may be 0.
- Saturation: a step that would move `pend` past +(2^(PEND_W−1)−1) or −2^(PEND_W−1) leaves `pend` unchanged and sets `ovf`. `angle` still steps.
- `_ZERO` low clears `angle`, `pend`, `ovf`, the gap timer and the sampler (→IDLE). No pulse is emitted that clock. `_ZERO` is overridden by `rst`.
- Reset values:
  - `angle` = 0; `_D15`..`_D21` = 1; `_CDUP` = `_CDUM` = 1; `ovf` = 0.
  - `pend` = 0; state IDLE; all timers 0.

## Timing
- Triggers are sampled on every rising `clk`; there is no input synchronizer (inputs are synchronous).
- Trigger rises at edge k with timer 0, fine rate: `angle` changes at edge k+`SLOW_DIV`−1; at high rate, at edge k+`FAST_DIV`−1.
- Steady-state step period: `SLOW_DIV`+`SETTLE` clocks (fine) and `FAST_DIV`+`SETTLE` clocks (high).
- `_Dn` is a combinational decode of the `angle` register: zero latency after the `angle` update.
- First output pulse: the clock after the step that makes `pend` nonzero, if the gap timer is idle. Pulses start ≥ `OUT_GAP` clocks apart.
- A pulse is exactly one clock wide. `_CDUP` and `_CDUM` are never low together.
- `rst` or `_ZERO` mid-pulse: the output returns high on the next edge.

## Test plan
- Reset: hold `rst` 3 clocks, triggers high → `angle`=0, all `_Dn`=1, no pulses, `ovf`=0.
- Fine up (defaults): `_TLF1H`=1, `_ERRNEG`=0 for 200 clocks → `angle`=3 (period 66), with 3 `_CDUP` pulses and `pend` returning to 0.
- High-rate down from 0: `_TLF2H`=1, `_ERRNEG`=1 → first step after 4 clocks to 0xFFFF (`_D15`..`_D21` all 0), then one step per 6 clocks.
- Pulse backlog: `FAST_DIV`=1, `SETTLE`=0, `OUT_GAP`=8, 40 up-steps → `pend` saturates at +31 and `ovf`=1. Pulses then drain at 8-clock spacing until `pend`=0.
- Direction reversal with a nonzero backlog: `pend`=+3, then 5 down-steps → net −2, which drains as `_CDUM` pulses. There is no clock with both outputs low.
- `_ZERO` during RUN with `pend`≠0 → next clock `angle`=0, `pend`=0, `ovf`=0. Pulses stop and the sampler restarts its timer from 0.
